instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Upstream stage of the single-cycle MIPS core. Owns the PC, fetches each instruction from instruction memory over a req/ack handshake, and holds it in an instruction register.
- Drives opCode (instr[31:26]) into the control unit, which registers its outputs on clk.
- Sequences each instruction as FETCH -> DECODE -> EXECUTE, so the registered control outputs and ALU Zero are valid when the next PC is computed.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles imem_req may wait for imem_ack before fault (range 2..65535)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  byte address of fetch, equal to pc
imem_ack  in  1  instruction memory returns data this cycle
imem_rdata  in  32  instruction word, valid when imem_ack=1
Jump  in  1  from control unit
Branch  in  1  from control unit
Zero  in  1  from ALU
stall  in  1  holds EXECUTE (datapath multi-cycle op / debug)
instr  out  32  instruction register
opCode  out  6  instr[31:26], to control unit
instr_valid  out  1  high in DECODE and EXECUTE
pc  out  32  address of current instruction
pc_plus4  out  32  pc + 4
fetch_err  out  1  sticky fault flag, imem timeout

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; instr=0 (so opCode=0); state=FETCH; timeout counter=0; fetch_err=0.
  - imem_req, instr_valid and imem_addr follow state/pc combinationally, so imem_req falls within the same cycle rst asserts.
  - First request issues in the first cycle after rst deasserts.
- States: FETCH, DECODE, EXECUTE, HALT. 2-bit encoding, declared in the package.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - On imem_ack: instr<=imem_rdata, go to DECODE, counter<=0.
  - Without ack: counter increments. When counter reaches TIMEOUT-1 with no ack: fetch_err<=1, go to HALT.
- DECODE:
  - Exactly 1 cycle; imem_req=0; instr_valid=1.
  - Control samples opCode at this cycle's end edge.
- EXECUTE:
  - instr_valid=1. Stays in EXECUTE while stall=1.
  - On the first edge with stall=0: pc<=next_pc, go to FETCH.
  - Minimum instruction time = 1 (ack) + 1 + 1 = 3 cycles with zero-wait memory.
- next_pc, evaluated on EXECUTE exit:
  - Jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. Jump has priority over Branch.
  - else Branch&Zero: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - else: pc_plus4.
  - All arithmetic is 32-bit modulo 2^32. pc=32'hFFFF_FFFC + 4 wraps to 0; negative offsets wrap the same way.
- HALT:
  - Terminal state; imem_req=0, instr_valid=0, pc frozen.
  - Only reset exits. fetch_err stays 1 until reset.
- imem_ack outside FETCH is ignored; instr is unchanged.
- imem_ack on the same cycle as the timeout limit: the ack wins. Capture the instruction; no fault.
- pc[1:0] is always 00: RESET_PC must be word-aligned, and every next_pc form preserves this.

Decomposition:
- Package mips_pkg:
  - state encoding: FETCH=2'd0, DECODE=2'd1, EXECUTE=2'd2, HALT=2'd3
  - opcode constants: OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW
  - RESET_PC default
- One sub-module, next_pc_calc: purely combinational; inputs pc_plus4, instr, Jump, Branch, Zero; output next_pc. Tested standalone.

Test Plan:
- Reset then zero-wait ack with imem_rdata=32'h8C01_0004 (LW) -> imem_addr=0 in the first cycle; opCode=6'b100011 in DECODE; pc=4 after EXECUTE; next imem_addr=4.
- At pc=32'h0000_0010, instr=32'h0800_0040 (J), Jump=1 in EXECUTE -> pc=32'h0000_0100. With Jump=1 and Branch=1, Zero=1 together, Jump still wins.
- At pc=32'h20, BEQ imm=16'hFFFE with Branch=1: Zero=1 -> pc=32'h1C; Zero=0 -> pc=32'h24.
- Ack delayed 5 cycles with TIMEOUT=16 -> imem_req high and imem_addr stable for 6 cycles; no fault. Ack never arrives -> fetch_err=1 after 16 FETCH cycles, HALT, imem_req=0.
- stall=1 for 3 cycles in EXECUTE -> pc unchanged and no new imem_req until stall drops. rst=0 asserted mid-stall -> pc=RESET_PC and imem_req=0 immediately (asynchronous).
- pc=32'hFFFF_FFFC, non-branch instruction -> next imem_addr=32'h0000_0000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: fetch state encoding,
// opcode constants and the branch-offset helper.
package mips_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DECODE  = 2'd1,
      EXECUTE = 2'd2,
      HALT    = 2'd3
   } fetch_state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Sign-extended, word-scaled branch displacement from an I-type instruction
   function automatic logic [31:0] branch_offset(input logic [31:0] instr);
      return {{14{instr[15]}}, instr[15:0], 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch, or sequential.
module next_pc_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        Zero,
   output logic [31:0] next_pc
);

   // Jump outranks a taken branch; all sums wrap modulo 2^32
   always_comb begin
      next_pc = pc_plus4;
      if (Jump) begin
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (Branch && Zero) begin
         next_pc = pc_plus4 + branch_offset(instr);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over an imem req/ack
// handshake with a timeout fault, and sequences FETCH/DECODE/EXECUTE.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        Zero,
   input  logic        stall,
   output logic [31:0] instr,
   output logic [5:0]  opCode,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_err
);

   localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT - 1);

   fetch_state_t state, state_next;
   logic [15:0]  wait_cnt;
   logic [31:0]  next_pc;

   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;
   assign opCode    = instr[31:26];

   next_pc_calc u_next_pc (
      .pc_plus4 (pc_plus4),
      .instr    (instr),
      .Jump     (Jump),
      .Branch   (Branch),
      .Zero     (Zero),
      .next_pc  (next_pc)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs; the request is qualified by rst so it
   // drops as soon as reset asserts even though the reset state is FETCH
   always_comb begin
      state_next  = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      unique case (state)
         FETCH: begin
            imem_req = rst;
            if (imem_ack) begin
               state_next = DECODE;
            end else if (wait_cnt == CNT_LIMIT) begin
               state_next = HALT;
            end
         end
         DECODE: begin
            instr_valid = 1'b1;
            state_next  = EXECUTE;
         end
         EXECUTE: begin
            instr_valid = 1'b1;
            if (!stall) begin
               state_next = FETCH;
            end
         end
         HALT: begin
            state_next = HALT;
         end
         default: state_next = FETCH;
      endcase
   end

   // Instruction capture, wait counter and sticky timeout fault
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr     <= '0;
         wait_cnt  <= '0;
         fetch_err <= 1'b0;
      end else if (state == FETCH) begin
         if (imem_ack) begin
            instr    <= imem_rdata;
            wait_cnt <= '0;
         end else if (wait_cnt == CNT_LIMIT) begin
            fetch_err <= 1'b1;
         end else begin
            wait_cnt <= wait_cnt + 16'd1;
         end
      end
   end

   // PC advances only when EXECUTE retires
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else if (state == EXECUTE && !stall) begin
         pc <= next_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: expected fetch addresses are queued
// when each instruction's control inputs are driven and compared when the
// next request appears.
module tb_instr_fetch;
   import mips_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        Jump = 1'b0;
   logic        Branch = 1'b0;
   logic        Zero = 1'b0;
   logic        stall = 1'b0;
   logic [31:0] instr;
   logic [5:0]  opCode;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_err;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] cur_pc = '0;

   always #5 clk = ~clk;

   instr_fetch #(
      .RESET_PC (RST_PC),
      .TIMEOUT  (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .Jump        (Jump),
      .Branch      (Branch),
      .Zero        (Zero),
      .stall       (stall),
      .instr       (instr),
      .opCode      (opCode),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .fetch_err   (fetch_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference next-PC, written arithmetically rather than by concatenation
   function automatic logic [31:0] ref_next(input logic [31:0] a, input logic [31:0] w,
                                            input logic j, input logic b, input logic z);
      logic [31:0] seq;
      int          off;
      seq = a + 32'd4;
      if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      if (b && z) begin
         off = int'($signed(w[15:0])) * 4;
         return seq + 32'(off);
      end
      return seq;
   endfunction

   // At a FETCH-cycle negedge: pop the expected address and compare
   task automatic start_fetch(input string tag);
      logic [31:0] e;
      if (exp_addr_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(exp_addr_q.size()), 32'd1);
         e = cur_pc;
      end else begin
         e = exp_addr_q.pop_front();
      end
      cur_pc = e;
      check({tag, "_pc"}, pc, e);
      check({tag, "_addr"}, imem_addr, e);
   endtask

   task automatic run_instr(input string tag, input logic [31:0] w, input int unsigned delay,
                            input logic j, input logic b, input logic z,
                            input int unsigned stall_n);
      start_fetch(tag);
      for (int unsigned i = 0; i < delay; i++) begin
         check({tag, "_req_wait"}, 32'(imem_req), 32'd1);
         check({tag, "_addr_wait"}, imem_addr, cur_pc);
         @(negedge clk);
      end
      check({tag, "_req"}, 32'(imem_req), 32'd1);
      imem_rdata = w;
      imem_ack   = 1'b1;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      check({tag, "_dec_op"}, 32'(opCode), 32'(w >> 26));
      check({tag, "_dec_valid"}, 32'(instr_valid), 32'd1);
      check({tag, "_dec_req"}, 32'(imem_req), 32'd0);
      check({tag, "_pc4"}, pc_plus4, cur_pc + 32'd4);
      Jump   = j;
      Branch = b;
      Zero   = z;
      stall  = (stall_n != 0);
      exp_addr_q.push_back(ref_next(cur_pc, w, j, b, z));
      @(negedge clk);
      check({tag, "_exe_valid"}, 32'(instr_valid), 32'd1);
      for (int unsigned s = 0; s < stall_n; s++) begin
         check({tag, "_stall_pc"}, pc, cur_pc);
         check({tag, "_stall_req"}, 32'(imem_req), 32'd0);
         check({tag, "_stall_instr"}, instr, w);
         imem_ack = 1'b1;
         @(negedge clk);
      end
      imem_ack = 1'b0;
      stall    = 1'b0;
      @(negedge clk);
      Jump   = 1'b0;
      Branch = 1'b0;
      Zero   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      exp_addr_q.delete();
      exp_addr_q.push_back(RST_PC);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_pc", pc, RST_PC);
      check("rst_instr", instr, 32'd0);
      check("rst_op", 32'(opCode), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_err", 32'(fetch_err), 32'd0);
      rst = 1'b1;
      #1;
      check("first_req", 32'(imem_req), 32'd1);
      exp_addr_q.push_back(RST_PC);

      run_instr("lw",        32'h8C01_0004, 0, 1'b0, 1'b0, 1'b0, 0);
      run_instr("j_delay",   32'h0800_0004, 5, 1'b1, 1'b0, 1'b0, 0);
      run_instr("j_prio",    32'h0800_0040, 0, 1'b1, 1'b1, 1'b1, 0);
      run_instr("j_back",    32'h0800_0008, 0, 1'b1, 1'b0, 1'b0, 0);
      run_instr("beq_taken", 32'h1000_FFFE, 0, 1'b0, 1'b1, 1'b1, 0);
      run_instr("j_20",      32'h0800_0008, 0, 1'b1, 1'b0, 1'b0, 0);
      run_instr("beq_nt",    32'h1000_FFFE, 0, 1'b0, 1'b1, 1'b0, 3);
      run_instr("j_0",       32'h0800_0000, 0, 1'b1, 1'b0, 1'b0, 0);
      run_instr("beq_wrap",  32'h1000_FFFE, 1, 1'b0, 1'b1, 1'b1, 0);
      run_instr("addi_top",  32'h2001_0001, 0, 1'b0, 1'b0, 1'b1, 0);

      // Asynchronous reset asserted while EXECUTE is stalled
      start_fetch("rst_mid");
      imem_rdata = 32'h8C01_0004;
      imem_ack   = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      stall    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_mid_pc_held", pc, cur_pc);
      check("rst_mid_req_held", 32'(imem_req), 32'd0);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_req", 32'(imem_req), 32'd0);
      check("rst_mid_pc", pc, RST_PC);
      check("rst_mid_valid", 32'(instr_valid), 32'd0);
      check("rst_mid_instr", instr, 32'd0);
      @(negedge clk);
      stall = 1'b0;
      rst   = 1'b1;
      #1;
      exp_addr_q.delete();
      exp_addr_q.push_back(RST_PC);
      run_instr("after_rst", 32'h8C01_0004, 0, 1'b0, 1'b0, 1'b0, 0);

      // Ack arriving on the final allowed wait cycle still wins
      do_reset();
      run_instr("ack_limit", 32'h2001_0001, 15, 1'b0, 1'b0, 1'b0, 0);
      check("ack_limit_err", 32'(fetch_err), 32'd0);

      // No ack at all: fault after 16 FETCH cycles, then HALT ignores ack
      do_reset();
      start_fetch("to");
      for (int i = 0; i < 16; i++) begin
         check("to_req_wait", 32'(imem_req), 32'd1);
         check("to_err_wait", 32'(fetch_err), 32'd0);
         @(negedge clk);
      end
      check("to_err", 32'(fetch_err), 32'd1);
      check("to_req", 32'(imem_req), 32'd0);
      check("to_valid", 32'(instr_valid), 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      for (int i = 0; i < 3; i++) @(negedge clk);
      imem_ack = 1'b0;
      check("halt_instr", instr, 32'd0);
      check("halt_pc", pc, RST_PC);
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_err", 32'(fetch_err), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
